rtlola_hlc_scheduler: RTL and testbench

//  High-level controller (HLC) in front of the generated RTLola monitor datapath. Merges input events
//  (rising edges of newX) and periodic deadlines into timestamped tasks, queues them, and sequences

---
 rtl/rtlola_hlc_scheduler_pkg.sv | 26 ++
 rtl/rtlola_hlc_scheduler_if.sv | 37 +++
 rtl/rtlola_hlc_scheduler_task_fifo.sv | 66 ++++++
 rtl/rtlola_hlc_scheduler.sv | 162 ++++++++++++++++
 tb/tb_rtlola_hlc_scheduler.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/rtlola_hlc_scheduler_pkg.sv
// Shared types and default sizing for the RTLola high-level controller.
package rtlola_sched_pkg;

  localparam int DATA_W_DEF        = 64;
  localparam int TS_W_DEF          = 64;
  localparam int PERIOD_CYCLES_DEF = 10000;
  localparam int NUM_LAYERS_DEF    = 3;
  localparam int QUEUE_DEPTH_DEF   = 4;

  // One queued unit of work for the monitor datapath.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] x;
    logic [TS_W_DEF-1:0]   ts;
    logic                  is_event;
    logic                  is_period;
  } task_t;

  // Dispatch phases seen by the monitor.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INPUT  = 2'd1,
    EVAL   = 2'd2,
    OUTPUT = 2'd3
  } phase_e;

endpackage

// File: rtl/rtlola_hlc_scheduler_if.sv
// Bundle of stream inputs and monitor-facing dispatch outputs of the HLC.
interface rtlola_hlc_if #(
  parameter int DATA_W      = 64,
  parameter int TS_W        = 64,
  parameter int NUM_LAYERS  = 3,
  parameter int QUEUE_DEPTH = 4
);

  logic                         en;
  logic [DATA_W-1:0]            x;
  logic                         newX;
  logic [DATA_W-1:0]            task_x;
  logic [TS_W-1:0]              task_ts;
  logic                         task_is_event;
  logic                         task_is_period;
  logic                         input_phase;
  logic [NUM_LAYERS-1:0]        layer_en;
  logic                         output_phase;
  logic                         busy;
  logic [$clog2(QUEUE_DEPTH):0] q_count;
  logic                         overflow;

  // Stream source / monitor side.
  modport master (
    output en, x, newX,
    input  task_x, task_ts, task_is_event, task_is_period,
    input  input_phase, layer_en, output_phase, busy, q_count, overflow
  );

  // Scheduler side.
  modport slave (
    input  en, x, newX,
    output task_x, task_ts, task_is_event, task_is_period,
    output input_phase, layer_en, output_phase, busy, q_count, overflow
  );

endinterface

// File: rtl/rtlola_hlc_scheduler_task_fifo.sv
// Synchronous first-word-fall-through FIFO of pending monitor tasks.
module rtlola_task_fifo
  import rtlola_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = task_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push;
  logic            do_pop;

  // A push into a full queue only fits when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Storage, pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rtlola_hlc_scheduler.sv
// RTLola high-level controller: timestamps input events and periodic deadlines,
// queues them, and walks each task through input, layer evaluation and output.
//
//  state  | meaning
//  IDLE   | no task in dispatch, waiting for a non-empty queue
//  INPUT  | monitor latches task_x of the queue head
//  EVAL   | one evaluation layer per cycle, layer_en = 1 << layer
//  OUTPUT | monitor outputs valid, head is popped
module rtlola_hlc_scheduler
  import rtlola_sched_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int TS_W          = TS_W_DEF,
  parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int NUM_LAYERS    = NUM_LAYERS_DEF,
  parameter int QUEUE_DEPTH   = QUEUE_DEPTH_DEF
) (
  input logic         clk,
  input logic         rst,
  rtlola_hlc_if.slave bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [TS_W-1:0]   ts;
    logic              is_event;
    logic              is_period;
  } entry_t;

  logic [TS_W-1:0] ts_q, ts_d;
  logic [PW-1:0]   per_q, per_d;
  logic            newx_q, newx_d;
  logic            ovf_q, ovf_d;
  phase_e          state_q, state_d;
  logic [LW-1:0]   layer_q, layer_d;

  logic            evt;
  logic            deadline;
  logic            push;
  logic            pop;
  entry_t          din;
  entry_t          head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Free-running timestamp, period counter and newX history, all frozen by en=0.
  always_comb begin
    ts_d   = ts_q;
    per_d  = per_q;
    newx_d = newx_q;
    if (bus.en) begin
      ts_d   = ts_q + TS_W'(1);
      per_d  = deadline ? '0 : per_q + PW'(1);
      newx_d = bus.newX;
    end
  end

  // Edge-detect, deadline and the merged queue entry; a coincident pair yields one entry.
  always_comb begin
    evt           = bus.newX && !newx_q;
    deadline      = (per_q == PW'(PERIOD_CYCLES - 1));
    push          = bus.en && (evt || deadline);
    pop           = bus.en && (state_q == OUTPUT);
    din.x         = bus.x;
    din.ts        = ts_q;
    din.is_event  = evt;
    din.is_period = deadline;
    ovf_d         = ovf_q | (push && fifo_full && !pop);
  end

  // Counter, history and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_q   <= '0;
      per_q  <= '0;
      newx_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      per_q  <= per_d;
      newx_q <= newx_d;
      ovf_q  <= ovf_d;
    end
  end

  rtlola_task_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register; reset abandons any task in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      layer_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
    end
  end

  // FSM next state; after OUTPUT go straight to INPUT if anything remains after the pop.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_d = INPUT;
        end
        INPUT: begin
          state_d = EVAL;
          layer_d = '0;
        end
        EVAL: begin
          if (layer_q == LW'(NUM_LAYERS - 1)) state_d = OUTPUT;
          else                                layer_d = layer_q + LW'(1);
        end
        OUTPUT: begin
          state_d = ((fifo_count > CW'(1)) || push) ? INPUT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; task fields show the queue head only while a task is in dispatch.
  always_comb begin
    bus.input_phase    = (state_q == INPUT);
    bus.layer_en       = (state_q == EVAL) ? (NUM_LAYERS'(1) << layer_q) : '0;
    bus.output_phase   = (state_q == OUTPUT);
    bus.task_x         = '0;
    bus.task_ts        = '0;
    bus.task_is_event  = 1'b0;
    bus.task_is_period = 1'b0;
    if (state_q != IDLE) begin
      bus.task_x         = head.x;
      bus.task_ts        = head.ts;
      bus.task_is_event  = head.is_event;
      bus.task_is_period = head.is_period;
    end
    bus.busy     = (state_q != IDLE) || !fifo_empty;
    bus.q_count  = fifo_count;
    bus.overflow = ovf_q;
  end

endmodule

// File: tb/tb_rtlola_hlc_scheduler.sv
// Directed bench for the RTLola HLC with PERIOD_CYCLES=16, NUM_LAYERS=3, QUEUE_DEPTH=4.
// Cycle n is the n-th cycle after reset release; in undisturbed runs the timestamp equals n.
module tb_rtlola_hlc_scheduler;

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   op_cnt     = 0;
  int   op_mark    = 0;

  rtlola_hlc_if #(.DATA_W(64), .TS_W(64), .NUM_LAYERS(3), .QUEUE_DEPTH(4)) bus ();

  rtlola_hlc_scheduler #(
    .DATA_W        (64),
    .TS_W          (64),
    .PERIOD_CYCLES (16),
    .NUM_LAYERS    (3),
    .QUEUE_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.output_phase === 1'b1) op_cnt++;
    chk("one_phase", 64'($countones({bus.input_phase, bus.layer_en, bus.output_phase}) <= 1), 64'd1);
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk_input(input string tag, input logic [63:0] ts, input logic ev, input logic per);
    chk({tag, "_input"}, 64'(bus.input_phase), 64'd1);
    chk({tag, "_ts"}, bus.task_ts, ts);
    chk({tag, "_event"}, 64'(bus.task_is_event), 64'(ev));
    chk({tag, "_period"}, 64'(bus.task_is_period), 64'(per));
  endtask

  task automatic chk_quiet(input string tag, input logic [63:0] ovf);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_qcount"}, 64'(bus.q_count), 64'd0);
    chk({tag, "_input"}, 64'(bus.input_phase), 64'd0);
    chk({tag, "_layer"}, 64'(bus.layer_en), 64'd0);
    chk({tag, "_output"}, 64'(bus.output_phase), 64'd0);
    chk({tag, "_task_x"}, bus.task_x, 64'd0);
    chk({tag, "_task_ts"}, bus.task_ts, 64'd0);
    chk({tag, "_flags"}, 64'({bus.task_is_event, bus.task_is_period}), 64'd0);
    chk({tag, "_overflow"}, 64'(bus.overflow), ovf);
  endtask

  initial begin
    bus.en   = 1'b1;
    bus.x    = '0;
    bus.newX = 1'b0;
    rst      = 1'b0;

    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset", 64'd0);
    rst = 1'b1;
    cyc = 0;

    // 2: single event, x=1, newX held four cycles (2..5)
    goto_cyc(2);
    bus.x    = 64'd1;
    bus.newX = 1'b1;
    step();  // cycle 3
    bus.x = 64'd99;
    op_mark = op_cnt;
    chk("ev_qcount", 64'(bus.q_count), 64'd1);
    chk("ev_busy", 64'(bus.busy), 64'd1);
    chk("ev_not_yet", 64'(bus.input_phase), 64'd0);
    step();  // cycle 4
    chk_input("ev", 64'd2, 1'b1, 1'b0);
    chk("ev_task_x", bus.task_x, 64'd1);
    step();
    chk("ev_layer0", 64'(bus.layer_en), 64'b001);
    step();  // cycle 6
    chk("ev_layer1", 64'(bus.layer_en), 64'b010);
    bus.newX = 1'b0;
    step();
    chk("ev_layer2", 64'(bus.layer_en), 64'b100);
    chk("ev_task_x_held", bus.task_x, 64'd1);
    step();  // cycle 8
    chk("ev_output", 64'(bus.output_phase), 64'd1);
    step();
    chk("ev_idle_busy", 64'(bus.busy), 64'd0);
    chk("ev_idle_task_x", bus.task_x, 64'd0);
    goto_cyc(14);
    chk("ev_one_output", 64'(op_cnt - op_mark), 64'd1);

    // 3: periodic deadlines at ts 15, 31, 47
    goto_cyc(17);
    chk_input("per15", 64'd15, 1'b0, 1'b1);
    goto_cyc(21);
    chk("per15_output", 64'(bus.output_phase), 64'd1);
    goto_cyc(33);
    chk_input("per31", 64'd31, 1'b0, 1'b1);
    goto_cyc(49);
    chk_input("per47", 64'd47, 1'b0, 1'b1);

    // 4: newX rises in the deadline cycle 63
    goto_cyc(63);
    bus.x    = 64'h5a;
    bus.newX = 1'b1;
    step();  // cycle 64
    bus.newX = 1'b0;
    chk("coin_qcount_push", 64'(bus.q_count), 64'd1);
    step();  // cycle 65
    chk_input("coin", 64'd63, 1'b1, 1'b1);
    chk("coin_task_x", bus.task_x, 64'h5a);
    chk("coin_qcount_disp", 64'(bus.q_count), 64'd1);
    goto_cyc(70);
    chk_quiet("coin_done", 64'd0);

    // 5: eight one-cycle pulses at 80,82..94 with deadlines at 79 and 95
    goto_cyc(79);
    bus.x = '0;
    for (int c = 80; c <= 121; c++) begin
      goto_cyc(c);
      bus.newX = (c <= 94) && (c % 2 == 0);
      if ((c <= 94) && (c % 2 == 0)) bus.x = 64'(c);
      if (c >= 81 && c <= 120) chk("ovf_busy", 64'(bus.busy), 64'd1);
      case (c)
        81:  chk_input("ovf_d79", 64'd79, 1'b0, 1'b1);
        86:  begin
               chk_input("ovf_e80", 64'd80, 1'b1, 1'b0);
               chk("ovf_e80_x", bus.task_x, 64'd80);
             end
        87:  chk("ovf_full", 64'(bus.q_count), 64'd4);
        88:  chk("ovf_before", 64'(bus.overflow), 64'd0);
        89:  chk("ovf_after", 64'(bus.overflow), 64'd1);
        91:  chk_input("ovf_e82", 64'd82, 1'b1, 1'b0);
        96:  chk_input("ovf_e84", 64'd84, 1'b1, 1'b0);
        101: chk_input("ovf_e86", 64'd86, 1'b1, 1'b0);
        106: begin
               chk_input("ovf_e90", 64'd90, 1'b1, 1'b0);
               chk("ovf_e90_x", bus.task_x, 64'd90);
             end
        111: chk_input("ovf_d95", 64'd95, 1'b0, 1'b1);
        116: chk_input("ovf_d111", 64'd111, 1'b0, 1'b1);
        121: chk("ovf_drained", 64'(bus.busy), 64'd0);
        default: ;
      endcase
    end

    // 6a: en low for five cycles during EVAL of the ts-127 deadline task
    goto_cyc(129);
    chk_input("en_d127", 64'd127, 1'b0, 1'b1);
    step();
    chk("en_layer0", 64'(bus.layer_en), 64'b001);
    step();  // cycle 131
    chk("en_layer1", 64'(bus.layer_en), 64'b010);
    bus.en = 1'b0;
    for (int c = 132; c <= 136; c++) begin
      goto_cyc(c);
      chk("en_hold_layer", 64'(bus.layer_en), 64'b010);
    end
    bus.en = 1'b1;
    step();  // cycle 137
    chk("en_layer2", 64'(bus.layer_en), 64'b100);
    step();
    chk("en_output", 64'(bus.output_phase), 64'd1);
    step();
    chk("en_idle", 64'(bus.busy), 64'd0);
    // timestamp and period counter lost five cycles: next deadline at ts 143, cycle 148
    goto_cyc(150);
    chk_input("en_d143", 64'd143, 1'b0, 1'b1);
    chk("en_ovf_sticky", 64'(bus.overflow), 64'd1);

    // 6b: reset during EVAL
    step();
    chk("rst_layer0", 64'(bus.layer_en), 64'b001);
    step();  // cycle 152
    chk("rst_layer1", 64'(bus.layer_en), 64'b010);
    rst = 1'b0;
    op_mark = op_cnt;
    step();  // cycle 153
    chk_quiet("rst_mid", 64'd0);
    step();  // cycle 154
    chk_quiet("rst_hold", 64'd0);
    rst = 1'b1;
    // timestamp restarts at 0 in cycle 154: first deadline at cycle 169
    goto_cyc(171);
    chk("rst_no_output", 64'(op_cnt - op_mark), 64'd0);
    chk_input("rst_d15", 64'd15, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
